// File: rtl/sfp_ctrl_if.sv
// Streaming ports of sfp_ctrl: partial-sum beat handshake (in_*) and result handshake (res_*).
// Valid/ready rule for both channels: a transfer happens on a rising clk edge where valid & ready are
// both 1; a producer holding valid keeps its payload stable until that edge, and ready may precede valid.
interface sfp_ctrl_if #(
  parameter int psum_bw = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [psum_bw-1:0] res;
  logic               res_valid;
  logic               res_ready;

  modport master (
    output in_valid,
    input  in_ready,
    input  res,
    input  res_valid,
    output res_ready
  );

  modport slave (
    input  in_valid,
    output in_ready,
    output res,
    output res_valid,
    input  res_ready
  );
endinterface

// File: rtl/sfp_ctrl.sv
// Sequencer for one accumulate/ReLU sfp lane: clear, stream len beats, ReLU, capture, present result.
// Optional macro SFP_CTRL_STALL_CNT_EN enables the saturating ACC bubble counter on stall_cnt.
module sfp_ctrl #(
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic               relu_en,
  output logic               busy,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic               sfp_reset,
  input  logic [psum_bw-1:0] sfp_out,
  output logic [15:0]        stall_cnt,
  output logic [2:0]         state_dbg,
  sfp_ctrl_if.slave          bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    RELU = 3'd3,
    CAP  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [len_bw-1:0]  cnt_q, cnt_d;
  logic               relu_q, relu_d;
  logic [psum_bw-1:0] res_q, res_d;
  logic               in_ready_c, acc_c, relu_c, res_valid_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      relu_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      relu_q  <= relu_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    relu_d      = relu_q;
    res_d       = res_q;
    in_ready_c  = 1'b0;
    acc_c       = 1'b0;
    relu_c      = 1'b0;
    res_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = len;
          relu_d  = relu_en;
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = (cnt_q != '0) ? ACC : RELU;
      end
      ACC: begin
        // sfp accumulates on exactly the cycles a beat is transferred
        in_ready_c = 1'b1;
        acc_c      = bus.in_valid;
        if (bus.in_valid) begin
          cnt_d = cnt_q - len_bw'(1);
          if (cnt_q == len_bw'(1)) state_d = RELU;
        end
      end
      RELU: begin
        relu_c  = relu_q;
        state_d = CAP;
      end
      CAP: begin
        res_d   = sfp_out;
        state_d = OUT;
      end
      OUT: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign sfp_acc       = acc_c;
  assign sfp_relu      = relu_c;
  // Controller reset also clears the sfp so a discarded command leaves no residue
  assign sfp_reset     = (state_q == CLR) | reset;
  assign bus.in_ready  = in_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.res       = res_q;
  assign state_dbg     = state_q;

`ifdef SFP_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == CLR) begin
      stall_q <= '0;
    end else if (state_q == ACC && !bus.in_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sfp_ctrl.sv
// Self-checking bench for sfp_ctrl: behavioural sfp lane, randomized commands, scoreboard on the result port.
module tb_sfp_ctrl;
  localparam int PW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic          relu_en;
  logic          busy;
  logic          sfp_acc, sfp_relu, sfp_reset;
  logic [PW-1:0] sfp_out;
  logic [15:0]   stall_cnt;
  logic [2:0]    state_dbg;
  logic [PW-1:0] beat_data;

  sfp_ctrl_if #(.psum_bw(PW)) bus ();

  sfp_ctrl #(.psum_bw(PW), .len_bw(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .relu_en   (relu_en),
    .busy      (busy),
    .sfp_acc   (sfp_acc),
    .sfp_relu  (sfp_relu),
    .sfp_reset (sfp_reset),
    .sfp_out   (sfp_out),
    .stall_cnt (stall_cnt),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural sfp lane (threshold 0) ----------------
  logic [PW-1:0] acc_m = '0;
  always @(posedge clk) begin
    if (sfp_reset)                    acc_m <= '0;
    else if (sfp_acc)                 acc_m <= acc_m + beat_data;
    else if (sfp_relu && acc_m[PW-1]) acc_m <= '0;
  end
  assign sfp_out = acc_m;

  // ---------------- scoreboard state ----------------
  logic [PW-1:0] exp_q[$];
  int            exp_rise_q[$];
  logic [PW-1:0] beats_q[$];
  int            gaps_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            t0 = 0;
  int            ir_cnt = 0;
  int            exp_len = 0;
  int            exp_bubbles = 0;
  int            rr_mode = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- res_ready driver ----------------
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       bus.res_ready = 1'($urandom_range(0, 1));
        1:       bus.res_ready = 1'b0;
        default: bus.res_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor: pops and compares on the result port ----------------
  initial begin : monitor
    logic          prev_v;
    logic          hs_prev;
    logic [PW-1:0] held;
    int            cnum;
    prev_v  = 1'b0;
    hs_prev = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_v  = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (bus.in_ready) ir_cnt++;
        if (hs_prev) chk("busy_after_handshake", busy, 0);
        hs_prev = 1'b0;
        if (bus.res_valid && !prev_v) begin
          held = bus.res;
          cnum = cyc - t0 + 1;
          if (exp_rise_q.size() == 0) fail_now("unexpected_res_valid");
          else chk("res_valid_cycle", cnum, exp_rise_q[0]);
        end else if (bus.res_valid) begin
          chk("res_stable", bus.res, held);
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_handshake");
          end else begin
            chk("res", bus.res, exp_q.pop_front());
            void'(exp_rise_q.pop_front());
          end
          hs_prev = 1'b1;
        end
        prev_v = bus.res_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input int l, input bit r);
    logic [PW-1:0] sum;
    int            nb;
    sum = '0;
    nb  = 0;
    for (int i = 0; i < l; i++) begin
      sum = sum + beats_q[i];
      nb  = nb + gaps_q[i];
    end
    if (r && sum[PW-1]) sum = '0;
    exp_q.push_back(sum);
    exp_rise_q.push_back(l + 4 + nb);
    exp_len     = l;
    exp_bubbles = nb;
    @(negedge clk);
    start        = 1'b1;
    len          = LW'(l);
    relu_en      = r;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    t0     = cyc;
    ir_cnt = 0;
    chk("start_accept", busy, 1);
    @(negedge clk);
    start   = 1'b0;
    len     = LW'($urandom);
    relu_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < l; i++) begin
      repeat (gaps_q[i]) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        beat_data    = PW'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      beat_data    = beats_q[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("timeout_waiting_idle");
    chk("acc_cycles", ir_cnt, exp_len + exp_bubbles);
`ifdef SFP_CTRL_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, exp_bubbles);
`else
    chk("stall_cnt", stall_cnt, 0);
`endif
  endtask

  task automatic wait_res_valid();
    int n;
    n = 0;
    while (!bus.res_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) fail_now("timeout_waiting_res_valid");
  endtask

  task automatic make_rand(input int l, input bit gap_en);
    beats_q.delete();
    gaps_q.delete();
    for (int i = 0; i < l; i++) begin
      if ($urandom_range(0, 1) == 1) beats_q.push_back(PW'($urandom));
      else                           beats_q.push_back(PW'($urandom_range(0, 40)) - PW'(20));
      gaps_q.push_back(gap_en ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    len          = '0;
    relu_en      = 1'b0;
    bus.in_valid = 1'b0;
    beat_data    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_sfp_acc", sfp_acc, 0);
    chk("rst_sfp_relu", sfp_relu, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_sfp_reset", sfp_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("sfp_reset_idle", sfp_reset, 0);

    // len 3, ReLU on, continuous beats 2,-1,3 -> 4, res_valid in cycle 7
    rr_mode = 2;
    beats_q = '{16'd2, 16'hFFFF, 16'd3};
    gaps_q  = '{0, 0, 0};
    issue_cmd(3, 1'b1);
    wait_idle();

    // len 2, beats -2,-3 with and without ReLU
    beats_q = '{16'hFFFE, 16'hFFFD};
    gaps_q  = '{0, 0};
    issue_cmd(2, 1'b1);
    wait_idle();
    issue_cmd(2, 1'b0);
    wait_idle();

    // len 4, two bubbles after beat 2 -> res_valid in cycle 10
    beats_q = '{16'd1, 16'd1, 16'd1, 16'd1};
    gaps_q  = '{0, 0, 2, 0};
    issue_cmd(4, 1'b1);
    wait_idle();

    // len 1, result back-pressured while start pulses during OUT
    rr_mode = 1;
    beats_q = '{16'd7};
    gaps_q  = '{0};
    issue_cmd(1, 1'b0);
    wait_res_valid();
    @(negedge clk);
    start   = 1'b1;
    len     = 8'd5;
    relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("out_held_busy", busy, 1);
    rr_mode = 2;
    wait_idle();
    repeat (4) begin
      @(negedge clk);
      chk("start_ignored_idle", busy, 0);
    end

    // asynchronous reset mid-ACC, then a fresh command
    @(negedge clk);
    start   = 1'b1;
    len     = 8'd3;
    relu_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    beat_data    = 16'd9;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_sfp_acc", sfp_acc, 0);
    chk("async_rst_sfp_reset", sfp_reset, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    beats_q = '{16'd5, 16'd6};
    gaps_q  = '{0, 0};
    issue_cmd(2, 1'($urandom_range(0, 1)));
    wait_idle();

    // len 0 -> no ACC cycles, result 0, res_valid in cycle 4
    beats_q.delete();
    gaps_q.delete();
    issue_cmd(0, 1'b1);
    wait_idle();

    // maximum length, continuous stream
    make_rand(255, 1'b0);
    issue_cmd(255, 1'($urandom_range(0, 1)));
    wait_idle();

    // randomized commands with bubbles and random back-pressure
    rr_mode = 0;
    for (int k = 0; k < 30; k++) begin
      int l;
      l = int'($urandom_range(0, 9));
      make_rand(l, 1'b1);
      issue_cmd(l, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "simulation time limit reached");
  end

endmodule
